pending_priority_encoder: RTL and testbench

- Parametrised, registered successor to the combinational 4-to-2 encoder.
- Latches one-cycle request pulses from N sources into a sticky pending register.
- Emits one encoded source index per handshake, in fixed-priority or round-robin order.
- Sits between peripheral/trap event lines and the core's trap/interrupt sequencer; the core consumes indices via valid/ready.

---
 rtl/pending_priority_encoder_pkg.sv | 11 +
 rtl/pending_priority_encoder_if.sv | 27 ++
 rtl/pending_priority_encoder_prio_select.sv | 35 +++
 rtl/pending_priority_encoder.sv | 87 ++++++++
 tb/tb_pending_priority_encoder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pending_priority_encoder_pkg.sv
// Shared constants and types for the pending priority encoder slice.
// Arbitration mode codes and the lost-event counter type.
package enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pending_priority_encoder_if.sv
// Request/index bus of the pending priority encoder.
// master: encoder side (req, out_ready in; out_valid, out_idx,
//   any_pending, drop_cnt out). slave: the driving/consuming side.
interface pending_priority_encoder_if
    import enc_pkg::*;
#(
    parameter int N = 8
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             any_pending;
    cnt_t             drop_cnt;

    modport master (
        input  req, out_ready,
        output out_valid, out_idx, any_pending, drop_cnt
    );

    modport slave (
        output req, out_ready,
        input  out_valid, out_idx, any_pending, drop_cnt
    );
endinterface

// File: rtl/pending_priority_encoder_prio_select.sv
// Combinational first-set-bit search starting at a pointer, with wrap.
// Ports: vec (candidates), start (first position), found, idx.
module prio_select #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Explicit modulo wrap so non-power-of-two N never aliases.
    function automatic logic [IDX_W-1:0] wrap_pos(
        input logic [IDX_W-1:0] s,
        input int               k
    );
        int p;
        p = int'(s) + k;
        if (p >= N) p = p - N;
        return p[IDX_W-1:0];
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && vec[wrap_pos(start, k)]) begin
                found = 1'b1;
                idx   = wrap_pos(start, k);
            end
        end
    end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky pending register for N event pulses, issuing one encoded index
// per valid/ready handshake in fixed-priority (MODE 0) or round-robin
// (MODE 1) order. Ports: clk, rst (sync, active-high), bus (master).
// Optional PENDING_ENC_LOSS_DETECT_EN builds the saturating drop_cnt.
module pending_priority_encoder
    import enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED
) (
    input  logic                           clk,
    input  logic                           rst,
    pending_priority_encoder_if.master     bus
);

    localparam int IDX_W = $clog2(N);
    typedef logic [IDX_W-1:0] idx_t;

    logic [N-1:0] pending;
    logic [N-1:0] clr;
    logic [N-1:0] pend_d;
    idx_t         rr_ptr;
    idx_t         start;
    idx_t         sel;
    logic         found;
    logic         load;

    assign start = (MODE == MODE_RR) ? rr_ptr : '0;

    prio_select #(.N(N)) u_sel (
        .vec   (pending),
        .start (start),
        .found (found),
        .idx   (sel)
    );

    assign load = (!bus.out_valid || bus.out_ready) && found;

    always_comb begin
        clr = '0;
        if (load) clr[sel] = 1'b1;
    end

    // A new pulse on the line being loaded re-arms it.
    assign pend_d = (pending & ~clr) | bus.req;

    assign bus.any_pending = |pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            rr_ptr        <= '0;
        end else begin
            pending <= pend_d;
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_idx   <= sel;
                rr_ptr        <= (sel == idx_t'(N - 1)) ? '0 : sel + 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef PENDING_ENC_LOSS_DETECT_EN
    logic dup;
    cnt_t drop_q;

    // Duplicate: a pulse that merges into an already-pending event.
    assign dup = |(bus.req & pending & ~clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (dup && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed bench for pending_priority_encoder, MODE 0 and MODE 1.
// Checks reset, ordering, stall, re-request and loss counting.
module tb_pending_priority_encoder;
    import enc_pkg::*;

    logic clk;
    logic rst;

    pending_priority_encoder_if #(.N(8)) b0 ();
    pending_priority_encoder_if #(.N(8)) b1 ();

    pending_priority_encoder #(.N(8), .MODE(MODE_FIXED)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.master)
    );

    pending_priority_encoder #(.N(8), .MODE(MODE_RR)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PENDING_ENC_LOSS_DETECT_EN
    localparam int EXP_DROP = 2;
`else
    localparam int EXP_DROP = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        b0.req = '0;
        b0.out_ready = 1'b0;
        b1.req = '0;
        b1.out_ready = 1'b0;

        // Reset with all requests high
        @(negedge clk);
        b0.req = 8'hFF;
        b1.req = 8'hFF;
        step();
        step();
        chk("rst_valid", b0.out_valid, 0);
        chk("rst_idx", b0.out_idx, 0);
        chk("rst_anyp", b0.any_pending, 0);
        chk("rst_drop", b0.drop_cnt, 0);
        chk("rst_valid_rr", b1.out_valid, 0);
        rst = 1'b0;
        b0.req = '0;
        b1.req = '0;
        step();
        step();
        step();
        chk("idle_valid", b0.out_valid, 0);
        chk("idle_anyp", b0.any_pending, 0);
        chk("idle_anyp_rr", b1.any_pending, 0);

        // Fixed priority: 2, 5, 7
        b0.req = 8'b1010_0100;
        b0.out_ready = 1'b1;
        step();
        b0.req = '0;
        chk("fp_lat_valid", b0.out_valid, 0);
        chk("fp_anyp", b0.any_pending, 1);
        step();
        chk("fp_v0", b0.out_valid, 1);
        chk("fp_i0", b0.out_idx, 2);
        step();
        chk("fp_i1", b0.out_idx, 5);
        step();
        chk("fp_i2", b0.out_idx, 7);
        chk("fp_v2", b0.out_valid, 1);
        step();
        chk("fp_end_valid", b0.out_valid, 0);
        chk("fp_end_anyp", b0.any_pending, 0);
        chk("fp_hold_idx", b0.out_idx, 7);

        // Stall: 3 held while req[1] pulses
        b0.out_ready = 1'b0;
        b0.req = 8'b0000_1000;
        step();
        b0.req = '0;
        step();
        chk("st_idx", b0.out_idx, 3);
        for (int i = 0; i < 5; i++) begin
            b0.req = (i == 1) ? 8'b0000_0010 : 8'h00;
            step();
            chk("st_hold_v", b0.out_valid, 1);
            chk("st_hold_i", b0.out_idx, 3);
        end
        b0.req = '0;
        b0.out_ready = 1'b1;
        step();
        chk("st_next_v", b0.out_valid, 1);
        chk("st_next_i", b0.out_idx, 1);
        step();
        chk("st_end_v", b0.out_valid, 0);

        // Same-cycle re-request of 4
        b0.req = 8'h10;
        step();
        b0.req = 8'h10;
        step();
        chk("rr4_v0", b0.out_valid, 1);
        chk("rr4_i0", b0.out_idx, 4);
        chk("rr4_anyp", b0.any_pending, 1);
        b0.req = '0;
        step();
        chk("rr4_v1", b0.out_valid, 1);
        chk("rr4_i1", b0.out_idx, 4);
        step();
        chk("rr4_end_v", b0.out_valid, 0);
        chk("rr4_drop", b0.drop_cnt, 0);

        // Loss detect: 6 pulsed 3 times while stalled
        b0.out_ready = 1'b0;
        b0.req = 8'h01;
        step();
        b0.req = '0;
        step();
        chk("ld_stall_i", b0.out_idx, 0);
        for (int i = 0; i < 3; i++) begin
            b0.req = 8'h40;
            step();
            b0.req = '0;
            step();
        end
        chk("ld_drop", b0.drop_cnt, EXP_DROP);
        chk("ld_stall_i2", b0.out_idx, 0);
        b0.out_ready = 1'b1;
        step();
        chk("ld_v6", b0.out_valid, 1);
        chk("ld_i6", b0.out_idx, 6);
        step();
        chk("ld_once", b0.out_valid, 0);
        chk("ld_anyp", b0.any_pending, 0);
        chk("ld_drop_hold", b0.drop_cnt, EXP_DROP);

        // Round-robin: 0, 1, 7 repeating
        b1.req = 8'b1000_0011;
        b1.out_ready = 1'b1;
        step();
        chk("rr_lat_v", b1.out_valid, 0);
        step();
        chk("rr_i0", b1.out_idx, 0);
        step();
        chk("rr_i1", b1.out_idx, 1);
        step();
        chk("rr_i2", b1.out_idx, 7);
        step();
        chk("rr_i3", b1.out_idx, 0);
        step();
        chk("rr_i4", b1.out_idx, 1);
        step();
        chk("rr_i5", b1.out_idx, 7);
        chk("rr_v5", b1.out_valid, 1);
        b1.req = '0;
        step();
        chk("rr_d0", b1.out_idx, 0);
        step();
        chk("rr_d1", b1.out_idx, 1);
        step();
        chk("rr_d2", b1.out_idx, 7);
        chk("rr_d2_v", b1.out_valid, 1);
        step();
        chk("rr_end_v", b1.out_valid, 0);
        chk("rr_end_anyp", b1.any_pending, 0);

        // Reset in flight discards pending work
        b1.req = 8'h0F;
        b1.out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        b1.req = '0;
        chk("rst2_v", b1.out_valid, 0);
        chk("rst2_anyp", b1.any_pending, 0);
        chk("rst2_idx", b1.out_idx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
